// File: rtl/vga_block_regs.sv
// Double-buffered register bank for the falling block, score and colour; shadow copies go live at a frame boundary.
// Optional score saturation at SCORE_MAX is enabled by defining VGA_REGS_SCORE_SAT_EN.
module vga_block_regs #(
    parameter logic [31:0] OFFSCREEN = 32'd1000,
    parameter logic [31:0] SCORE_MAX = 32'd9999
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        frame_start,
    output logic [31:0] b1x,
    output logic [31:0] b1y,
    output logic [31:0] b2x,
    output logic [31:0] b2y,
    output logic [31:0] b3x,
    output logic [31:0] b3y,
    output logic [31:0] b4x,
    output logic [31:0] b4y,
    output logic [31:0] score,
    output logic [31:0] blockType,
    output logic        commit_pending,
    output logic [31:0] frame_count
);

`ifdef VGA_REGS_SCORE_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam int NREGS = 10;
    localparam logic [3:0] ADDR_SCORE  = 4'd8;
    localparam logic [3:0] ADDR_COMMIT = 4'd10;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t      state_r;
    logic        pending_r;
    logic [31:0] shadow_r [NREGS];
    logic [31:0] active_r [NREGS];
    logic [31:0] frame_count_r;
    logic        commit_wr_s;
    logic        shadow_wr_s;

    function automatic logic [31:0] score_value(input logic [31:0] d);
        if (SAT_EN && (d > SCORE_MAX)) begin
            score_value = SCORE_MAX;
        end else begin
            score_value = d;
        end
    endfunction

    function automatic logic [31:0] reset_value(input int idx);
        if (idx < 8) begin
            reset_value = OFFSCREEN;
        end else begin
            reset_value = 32'd0;
        end
    endfunction

    assign commit_wr_s = wr_en && (wr_addr == ADDR_COMMIT);
    assign shadow_wr_s = wr_en && (wr_addr < ADDR_COMMIT);

    // Shadow bank: CPU writes land here only
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < NREGS; i++) begin
                shadow_r[i] <= reset_value(i);
            end
        end else if (shadow_wr_s) begin
            shadow_r[wr_addr] <= (wr_addr == ADDR_SCORE) ? score_value(wr_data) : wr_data;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Commit FSM; the copy samples shadow as it was before this edge's write
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            pending_r <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                active_r[i] <= reset_value(i);
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (commit_wr_s) begin
                        state_r   <= ST_PENDING;
                        pending_r <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        pending_r <= 1'b0;
                    end
                end
                ST_PENDING: begin
                    if (frame_start) begin
                        active_r  <= shadow_r;
                        state_r   <= commit_wr_s ? ST_PENDING : ST_IDLE;
                        pending_r <= commit_wr_s;
                    end else begin
                        state_r   <= ST_PENDING;
                        pending_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    pending_r <= 1'b0;
                end
            endcase
        end
    end

    // Free-running frame counter, wraps naturally
    always_ff @(posedge clock) begin
        if (!resetn) begin
            frame_count_r <= 32'd0;
        end else if (frame_start) begin
            frame_count_r <= frame_count_r + 32'd1;
        end else begin
            frame_count_r <= frame_count_r;
        end
    end

    assign b1x            = active_r[0];
    assign b1y            = active_r[1];
    assign b2x            = active_r[2];
    assign b2y            = active_r[3];
    assign b3x            = active_r[4];
    assign b3y            = active_r[5];
    assign b4x            = active_r[6];
    assign b4y            = active_r[7];
    assign score          = active_r[8];
    assign blockType      = active_r[9];
    assign commit_pending = pending_r;
    assign frame_count    = frame_count_r;

endmodule
